// File: rtl/kbd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : kbd_pkg
// Brief    : Scan-code constants and channel state encoding for the keyboard
//            action controller.
// Revision : 1.0 - initial release
// ============================================================================
package kbd_pkg;

  localparam logic [8:0] KEY_ENTER = 9'h05A;
  localparam logic [8:0] KEY_A     = 9'h01C;
  localparam logic [8:0] KEY_D     = 9'h023;
  localparam logic [8:0] KEY_S     = 9'h01B;
  localparam logic [8:0] KEY_F     = 9'h02B;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } chan_state_t;

endpackage
`default_nettype wire

// File: rtl/kbd_repeat_chan.sv
`default_nettype none
// ============================================================================
// Module   : kbd_repeat_chan
// Brief    : One action channel: press pulse, optional auto-repeat, and a
//            blocked flag that swallows keys already held while disabled.
// Revision : 1.0 - initial release
// ============================================================================
module kbd_repeat_chan
  import kbd_pkg::*;
#(
  parameter int REPEAT_DELAY  = 20_000_000,
  parameter int REPEAT_PERIOD = 5_000_000,
  parameter bit REPEAT_EN     = 1'b1,
  parameter int CNT_W         = $clog2((REPEAT_DELAY > REPEAT_PERIOD) ?
                                       REPEAT_DELAY : REPEAT_PERIOD) + 1
) (
  input  logic clk,
  input  logic rst,
  input  logic key,
  input  logic enable,
  input  logic mute,
  output logic pulse
);

  localparam logic [CNT_W-1:0] c_delay_last  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] c_period_last = CNT_W'(REPEAT_PERIOD - 1);
  localparam logic [CNT_W-1:0] c_cnt_one     = CNT_W'(1);

  chan_state_t      r_state;
  chan_state_t      w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_blocked;
  logic             w_blocked_nxt;
  logic             r_pulse;
  logic             w_pulse_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_blocked <= 1'b0;
      r_pulse   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_blocked <= w_blocked_nxt;
      r_pulse   <= w_pulse_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_blocked_nxt = r_blocked;
    w_pulse_nxt   = 1'b0;
    if (!key) begin
      w_state_nxt   = IDLE;
      w_cnt_nxt     = '0;
      w_blocked_nxt = 1'b0;
    end else if (!enable) begin
      // Remember the key was down while disabled so enabling never fires it.
      w_state_nxt   = IDLE;
      w_cnt_nxt     = '0;
      w_blocked_nxt = 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (!r_blocked) begin
            w_state_nxt = DELAY;
            w_cnt_nxt   = '0;
            w_pulse_nxt = ~mute;
          end
        end
        DELAY: begin
          if (mute) begin
            w_cnt_nxt = '0;
          end else if (REPEAT_EN) begin
            if (r_cnt == c_delay_last) begin
              w_state_nxt = REPEAT;
              w_cnt_nxt   = '0;
              w_pulse_nxt = 1'b1;
            end else begin
              w_cnt_nxt = r_cnt + c_cnt_one;
            end
          end
        end
        REPEAT: begin
          // A muted channel restarts its full initial delay once unmuted.
          if (mute) begin
            w_state_nxt = DELAY;
            w_cnt_nxt   = '0;
          end else if (r_cnt == c_period_last) begin
            w_cnt_nxt   = '0;
            w_pulse_nxt = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + c_cnt_one;
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  assign pulse = r_pulse;

endmodule
`default_nettype wire

// File: rtl/kbd_action_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : kbd_action_ctrl
// Brief    : Maps N_ACT scan codes to registered levels and press/auto-repeat
//            action pulses. Define KBD_LAST_WINS_EN to make channels 1 and 2
//            an opposing pair where only the newest held key pulses
//            (requires N_ACT >= 3).
// Revision : 1.0 - initial release
// ============================================================================
module kbd_action_ctrl
  import kbd_pkg::*;
#(
  parameter int                 N_ACT         = 3,
  parameter logic [N_ACT*9-1:0] KEY_CODES     = {KEY_D, KEY_A, KEY_ENTER},
  parameter logic [N_ACT-1:0]   REPEAT_MASK   = 3'b110,
  parameter int                 REPEAT_DELAY  = 20_000_000,
  parameter int                 REPEAT_PERIOD = 5_000_000,
  parameter int                 CNT_W         = $clog2((REPEAT_DELAY > REPEAT_PERIOD) ?
                                                       REPEAT_DELAY : REPEAT_PERIOD) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [511:0]     key_down,
  input  logic             enable,
  output logic [N_ACT-1:0] act_level,
  output logic [N_ACT-1:0] act_pulse
);

  logic [N_ACT-1:0] w_key;
  logic [N_ACT-1:0] w_mute;
  logic [N_ACT-1:0] r_level;
  logic             w_unused_keys;

  assign w_unused_keys = ^key_down;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_level <= '0;
    end else begin
      r_level <= w_key;
    end
  end

  assign act_level = r_level;

`ifdef KBD_LAST_WINS_EN
  logic r_right_newer;
  logic w_right_newer;
  logic w_rise_left;
  logic w_rise_right;
  logic w_both;

  assign w_rise_left   = w_key[1] & ~r_level[1];
  assign w_rise_right  = w_key[2] & ~r_level[2];
  // Simultaneous presses resolve in favour of the right-hand channel.
  assign w_right_newer = w_rise_right ? 1'b1 : (w_rise_left ? 1'b0 : r_right_newer);
  assign w_both        = w_key[1] & w_key[2];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_right_newer <= 1'b0;
    end else begin
      r_right_newer <= w_right_newer;
    end
  end

  always_comb begin
    w_mute    = '0;
    w_mute[1] = w_both & w_right_newer;
    w_mute[2] = w_both & ~w_right_newer;
  end
`else
  assign w_mute = '0;
`endif

  for (genvar i = 0; i < N_ACT; i++) begin : g_chan
    assign w_key[i] = key_down[KEY_CODES[9*i +: 9]];

    kbd_repeat_chan #(
      .REPEAT_DELAY  (REPEAT_DELAY),
      .REPEAT_PERIOD (REPEAT_PERIOD),
      .REPEAT_EN     (REPEAT_MASK[i]),
      .CNT_W         (CNT_W)
    ) u_chan (
      .clk    (clk),
      .rst    (rst),
      .key    (w_key[i]),
      .enable (enable),
      .mute   (w_mute[i]),
      .pulse  (act_pulse[i])
    );
  end

endmodule
`default_nettype wire
